fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one `fifo` write port among N requesters. Requesters use a hold-until-ack handshake; grants can burst up to BURST words per owner. One skid/stage register decouples arbitration from FIFO backpressure. The block sits between the producer blocks (RTC/register readers, input decoders) and the shared output FIFO.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/fifo_arb_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types, default parameters and width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_B     = 8;
  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_BURST = 4;
  localparam int unsigned DEF_CW    = 16;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t IDLE = 1'b0;
  localparam arb_state_t OWN  = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotating priority encoder: first set req bit at or above start, wrapping at N.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N  = DEF_N,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] idx
);

  localparam int unsigned SW = IW + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [SW-1:0]  sum;

  // Rotate so that bit 0 is the start position, then find the lowest set bit.
  always_comb begin
    dbl   = {req, req} >> start;
    rot   = dbl[N-1:0];
    valid = |req;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, start} + {1'b0, off};
    idx = (sum >= SW'(N)) ? IW'(sum - SW'(N)) : IW'(sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port through a single stage register.
// Optional stall statistics counter enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned B     = DEF_B,
  parameter  int unsigned N     = DEF_N,
  parameter  int unsigned BURST = DEF_BURST,
  parameter  int unsigned CW    = DEF_CW,
  localparam int unsigned IW    = idx_w(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*B-1:0]  req_data,
  output logic [N-1:0]    ack,
  input  logic            fifo_full,
  output logic            fifo_wr,
  output logic [B-1:0]    fifo_w_data,
  output logic [IW-1:0]   stage_src,
  output logic            busy,
  output logic [CW-1:0]   stall_cnt
);

  localparam int unsigned BCW = idx_w(BURST + 1);

  arb_state_t     state, state_nxt;
  logic [IW-1:0]  owner, owner_nxt;
  logic [IW-1:0]  last_owner, last_owner_nxt;
  logic [BCW-1:0] burst_cnt, burst_cnt_nxt;

  logic           stage_valid;
  logic [B-1:0]   stage_data;

  logic [B-1:0]   words [N];
  logic [IW-1:0]  start;
  logic           pick_valid;
  logic [IW-1:0]  pick_idx;
  logic           owner_hold;
  logic           grant_valid;
  logic [IW-1:0]  grant;
  logic           load_en;
  logic           take;
  logic [BCW-1:0] prev_cnt;
  logic [BCW-1:0] cnt_inc;

  fifo_arb_rr_pick #(.N(N)) u_pick (
    .req   (req),
    .start (start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Grant selection: a locked owner keeps the port while it still requests.
  always_comb begin
    for (int i = 0; i < N; i++) words[i] = req_data[i*B +: B];
    start       = (last_owner == IW'(N - 1)) ? '0 : last_owner + IW'(1);
    owner_hold  = (state == OWN) && req[owner];
    grant_valid = owner_hold || pick_valid;
    grant       = owner_hold ? owner : pick_idx;
    load_en     = ~stage_valid | ~fifo_full;
    take        = load_en & grant_valid & ~reset;
    ack         = take ? (N'(1) << grant) : '0;
    fifo_wr     = stage_valid & ~fifo_full;
    fifo_w_data = stage_data;
    busy        = (state == OWN);
  end

  // Next-state: release on dropped request, then burst accounting on an accepted word.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    prev_cnt       = owner_hold ? burst_cnt : '0;
    cnt_inc        = prev_cnt + BCW'(1);
    if ((state == OWN) && !req[owner]) begin
      state_nxt      = IDLE;
      last_owner_nxt = owner;
      burst_cnt_nxt  = '0;
    end
    if (take) begin
      if (32'(cnt_inc) < BURST) begin
        state_nxt     = OWN;
        owner_nxt     = grant;
        burst_cnt_nxt = cnt_inc;
      end else begin
        state_nxt      = IDLE;
        last_owner_nxt = grant;
        burst_cnt_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= IW'(N - 1);
      burst_cnt   <= '0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
      stage_src   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
      if (load_en) begin
        stage_valid <= grant_valid;
        if (grant_valid) begin
          stage_data <= words[grant];
          stage_src  <= grant;
        end
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [CW-1:0] stall_q;

  // Saturating count of cycles where someone waits on a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (|req && !load_en && (stall_q != '1)) begin
      stall_q <= stall_q + CW'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a BURST=4 and a BURST=1 instance share stimulus; directed table plus random run.
module tb_fifo_wr_arbiter;

  localparam int unsigned B  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 16;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic       rst;
    logic [3:0] ack4;
    logic [3:0] ack1;
    logic       wr;
    logic       busy4;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   req;
  logic           fifo_full;
  logic [N*B-1:0] req_data    [2];
  logic [N-1:0]   ack         [2];
  logic           fifo_wr     [2];
  logic [B-1:0]   fifo_w_data [2];
  logic [1:0]     stage_src   [2];
  logic           busy        [2];
  logic [CW-1:0]  stall_cnt   [2];

  fifo_wr_arbiter #(.B(B), .N(N), .BURST(4), .CW(CW)) dut_b4 (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data[0]), .ack(ack[0]),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr[0]), .fifo_w_data(fifo_w_data[0]),
    .stage_src(stage_src[0]), .busy(busy[0]), .stall_cnt(stall_cnt[0])
  );

  fifo_wr_arbiter #(.B(B), .N(N), .BURST(1), .CW(CW)) dut_b1 (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data[1]), .ack(ack[1]),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr[1]), .fifo_w_data(fifo_w_data[1]),
    .stage_src(stage_src[1]), .busy(busy[1]), .stall_cnt(stall_cnt[1])
  );

  // Reference model state per instance (0: BURST=4, 1: BURST=1)
  bit          m_sv    [2];
  logic [7:0]  m_sd    [2];
  int          m_ss    [2];
  bit          m_lock  [2];
  int          m_own   [2];
  int          m_last  [2];
  int          m_cnt   [2];
  int          m_stall [2];
  logic [7:0]  cur_word [2][N];
  bit          rnd_words;

  int n_chk  = 0;
  int n_pass = 0;

  vec_t vt [39];
  vec_t dummy;

  function automatic int burst_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic model_reset(input int d);
    m_sv[d] = 0; m_sd[d] = 8'h00; m_ss[d] = 0; m_lock[d] = 0;
    m_own[d] = 0; m_last[d] = N - 1; m_cnt[d] = 0; m_stall[d] = 0;
  endtask

  function automatic void pick(input int d, input logic [N-1:0] r, output int g, output bit gv);
    int i;
    g = 0; gv = 0;
    if (m_lock[d] && r[m_own[d]]) begin
      g = m_own[d]; gv = 1;
      return;
    end
    for (int k = 1; k <= N; k++) begin
      i = (m_last[d] + k) % N;
      if (r[i]) begin
        g = i; gv = 1;
        return;
      end
    end
  endfunction

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (burst%0d) t=%0t got %0h expected %0h", nm, burst_of(d), $time, act, exp);
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic full, input logic rst,
                       input bit use_tab, input vec_t v);
    int         g   [2];
    bit         gv  [2];
    bit         ld  [2];
    logic [3:0] ea;
    int         n;
    bit         lock_pre;
    int         own_pre;
    req = r; fifo_full = full; reset = rst;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) req_data[d][i*B +: B] = cur_word[d][i];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      pick(d, r, g[d], gv[d]);
      ld[d] = !m_sv[d] || !full;
      ea = (ld[d] && gv[d] && !rst) ? (4'b0001 << g[d]) : 4'b0000;
      chk(d, "ack", 32'(ack[d]), 32'(ea));
      chk(d, "fifo_wr", 32'(fifo_wr[d]), 32'(m_sv[d] && !full));
      chk(d, "fifo_w_data", 32'(fifo_w_data[d]), 32'(m_sd[d]));
      chk(d, "stage_src", 32'(stage_src[d]), 32'(m_ss[d]));
      chk(d, "busy", 32'(busy[d]), 32'(m_lock[d]));
`ifdef FIFO_ARB_STATS_EN
      chk(d, "stall_cnt", 32'(stall_cnt[d]), 32'(m_stall[d]));
`else
      chk(d, "stall_cnt", 32'(stall_cnt[d]), 32'd0);
`endif
      if (use_tab) begin
        chk(d, "tab_ack", 32'(ack[d]), 32'((d == 0) ? v.ack4 : v.ack1));
        chk(d, "tab_wr", 32'(fifo_wr[d]), 32'(v.wr));
        if (d == 0) chk(d, "tab_busy", 32'(busy[d]), 32'(v.busy4));
        else        chk(d, "tab_busy", 32'(busy[d]), 32'd0);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        model_reset(d);
      end else begin
        if (|r && !ld[d] && m_stall[d] != 32'hffff) m_stall[d]++;
        lock_pre = m_lock[d];
        own_pre  = m_own[d];
        if (m_lock[d] && !r[m_own[d]]) begin
          m_lock[d] = 0;
          m_last[d] = m_own[d];
        end
        if (ld[d]) begin
          if (gv[d]) begin
            m_sv[d] = 1;
            m_sd[d] = cur_word[d][g[d]];
            m_ss[d] = g[d];
            n = ((lock_pre && own_pre == g[d]) ? m_cnt[d] : 0) + 1;
            if (n < burst_of(d)) begin
              m_lock[d] = 1; m_own[d] = g[d]; m_cnt[d] = n;
            end else begin
              m_lock[d] = 0; m_last[d] = g[d]; m_cnt[d] = 0;
            end
            if (rnd_words) cur_word[d][g[d]] = 8'($urandom);
            else           cur_word[d][g[d]] = cur_word[d][g[d]] + 8'h10;
          end else begin
            m_sv[d] = 0;
          end
        end
      end
    end
    #1;
  endtask

  initial begin
    // Directed table: burst rotation, wrap-around, owner drop, FIFO stall, mid-run reset
    vt[0] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    for (int k = 1; k <= 16; k++)
      vt[k] = '{4'b1111, 1'b0, 1'b0, 4'(1 << ((k - 1) / 4)), 4'(1 << ((k - 1) % 4)),
                (k > 1), (((k - 1) % 4) != 0)};
    vt[17] = '{4'b1001, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0};
    vt[18] = '{4'b1001, 1'b0, 1'b0, 4'b0001, 4'b1000, 1'b1, 1'b1};
    vt[19] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1};
    vt[20] = '{4'b0101, 1'b0, 1'b0, 4'b0100, 4'b0001, 1'b1, 1'b1};
    vt[21] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1};
    vt[22] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vt[23] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0};
    vt[24] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1};
    for (int k = 25; k <= 29; k++)
      vt[k] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vt[30] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1};
    vt[31] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1};
    vt[32] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vt[33] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vt[34] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0};
    vt[35] = '{4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1};
    vt[36] = '{4'b1111, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0};
    vt[37] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1};
    vt[38] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    dummy  = vt[0];

    rnd_words = 0;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      for (int i = 0; i < N; i++) cur_word[d][i] = 8'(8'h10 + i);
      req_data[d] = '0;
    end
    req = '0; fifo_full = 1'b0; reset = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 39; k++) cycle(vt[k].req, vt[k].full, vt[k].rst, 1'b1, vt[k]);

    // Random traffic with withdrawals, backpressure and occasional reset
    rnd_words = 1;
    for (int k = 0; k < 800; k++)
      cycle(4'($urandom), ($urandom_range(3) == 0), ($urandom_range(63) == 0), 1'b0, dummy);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
